// File: rtl/mmsr_pkg.sv
// Shared encodings, CRC constants and FSM state type for
// the 802.3br preemptable receive path.
package mmsr_pkg;

    localparam logic [7:0] PRE_B = 8'h55;
    localparam logic [7:0] SFD_B = 8'hD5;

    // Index n of each packed array is the encoding for n.
    localparam logic [3:0][7:0] SMD_S =
        {8'hB3, 8'h7F, 8'h4C, 8'hE6};
    localparam logic [3:0][7:0] SMD_C =
        {8'h9E, 8'h2A, 8'h52, 8'h61};
    localparam logic [3:0][7:0] FRAG_CNT_B =
        {8'hB3, 8'h7F, 8'h4C, 8'hE6};

    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
    // Register value after running a frame plus its FCS.
    localparam logic [31:0] FCS_RESIDUE = 32'hDEBB_20E3;
    localparam logic [31:0] MCRC_XOR = 32'h0000_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_FRAG_CNT,
        ST_DATA,
        ST_FLUSH,
        ST_DISCARD,
        ST_ABORT
    } state_e;

    typedef enum logic [1:0] {
        B_PRE,
        B_SMDS,
        B_SMDC,
        B_OTHER
    } byte_kind_e;

    typedef struct packed {
        byte_kind_e kind;
        logic [1:0] idx;
    } smd_t;

    function automatic smd_t smd_decode(input logic [7:0] b);
        smd_t r;
        r.kind = B_OTHER;
        r.idx  = 2'd0;
        if (b == PRE_B) r.kind = B_PRE;
        for (int i = 0; i < 4; i++) begin
            if (b == SMD_S[i]) begin
                r.kind = B_SMDS;
                r.idx  = 2'(i);
            end
            if (b == SMD_C[i]) begin
                r.kind = B_SMDC;
                r.idx  = 2'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mmsr_crc32_byte.sv
// Reflected CRC-32, one byte per clock, with
// synchronous init and update enable.
module mmsr_crc32_byte
    import mmsr_pkg::*;
(
    input  logic        clk,
    input  logic        reset_begin,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    logic [31:0] nxt;

    always_comb begin
        nxt = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            nxt = nxt[0] ? ((nxt >> 1) ^ CRC_POLY)
                         : (nxt >> 1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset_begin)  crc <= CRC_INIT;
        else if (init)    crc <= CRC_INIT;
        else if (en)      crc <= nxt;
    end

endmodule

// File: rtl/mmsr_preempt_rx_proc.sv
// pMAC-side receive: SMD-S/SMD-C handling, fragment checks
// and reassembly into one continuous pRX_DV frame.
module mmsr_preempt_rx_proc
    import mmsr_pkg::*;
#(
    parameter int MIN_FRAG_BYTES = 64,
    parameter int CNT_W          = 11
) (
    input  logic       clk,
    input  logic       reset_begin,
    input  logic       rRxDv,
    input  logic       rByteReady,
    input  logic [7:0] rRX_DATA,
    output logic       pRX_DV,
    output logic       pRX_VALID,
    output logic [7:0] pRX_DATA,
    output logic       pRX_ER,
    output logic       frame_active
);

    localparam logic [CNT_W-1:0] MIN_CNT =
        CNT_W'(MIN_FRAG_BYTES);

    state_e state, state_nxt;
    smd_t   sd;

    logic [1:0]       frame_num, exp_frag, fc_idx;
    logic [CNT_W-1:0] cnt;
    logic [3:0][7:0]  hb;
    logic [2:0]       hb_n;
    logic [31:0]      crc, fcs, hb_word;
    logic             hb_full, fcs_hit, mcrc_hit;

    logic start, push, fcnt_ok, abort;
    logic frag_end, flush_pop, close, clr;

    assign sd      = smd_decode(rRX_DATA);
    assign hb_full = (hb_n == 3'd4);
    // hb[0] is the oldest byte, i.e. first on the wire.
    assign hb_word = {hb[0], hb[1], hb[2], hb[3]};
    assign fcs     = {~crc[7:0], ~crc[15:8],
                      ~crc[23:16], ~crc[31:24]};
    assign fcs_hit  = hb_full && (hb_word == fcs);
    assign mcrc_hit = hb_full
                   && (hb_word == (fcs ^ MCRC_XOR))
                   && (cnt >= MIN_CNT);
    // exp_frag counts closed fragments; the continuation
    // after fragment k carries frag_count k-1.
    assign fc_idx = exp_frag - 2'd1;

    mmsr_crc32_byte u_crc (
        .clk         (clk),
        .reset_begin (reset_begin),
        .init        (start),
        .en          (push && hb_full),
        .data        (hb[0]),
        .crc         (crc)
    );

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        push      = 1'b0;
        fcnt_ok   = 1'b0;
        abort     = 1'b0;
        frag_end  = 1'b0;
        flush_pop = 1'b0;
        close     = 1'b0;
        clr       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (rRxDv) state_nxt = ST_PREAMBLE;
            end
            ST_PREAMBLE: begin
                if (rByteReady) begin
                    unique case (sd.kind)
                        B_PRE:  state_nxt = ST_PREAMBLE;
                        B_SMDS: begin
                            if (frame_active) abort = 1'b1;
                            else begin
                                start     = 1'b1;
                                state_nxt = ST_DATA;
                            end
                        end
                        B_SMDC: begin
                            if (!frame_active)
                                state_nxt = ST_DISCARD;
                            else if (sd.idx == frame_num)
                                state_nxt = ST_FRAG_CNT;
                            else
                                abort = 1'b1;
                        end
                        default: state_nxt = ST_DISCARD;
                    endcase
                end else if (!rRxDv) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_FRAG_CNT: begin
                if (rByteReady) begin
                    if (rRX_DATA == FRAG_CNT_B[fc_idx]) begin
                        fcnt_ok   = 1'b1;
                        state_nxt = ST_DATA;
                    end else begin
                        abort = 1'b1;
                    end
                end else if (!rRxDv) begin
                    abort = 1'b1;
                end
            end
            ST_DATA: begin
                if (rByteReady) begin
                    push = 1'b1;
                end else if (!rRxDv) begin
                    unique case (1'b1)
                        fcs_hit:  state_nxt = ST_FLUSH;
                        mcrc_hit: begin
                            frag_end  = 1'b1;
                            state_nxt = ST_IDLE;
                        end
                        default:  abort = 1'b1;
                    endcase
                end
            end
            ST_FLUSH: begin
                if (hb_n != 3'd0) begin
                    flush_pop = 1'b1;
                end else begin
                    close     = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                if (!rRxDv) state_nxt = ST_IDLE;
            end
            ST_ABORT: begin
                clr       = 1'b1;
                state_nxt = rRxDv ? ST_DISCARD : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (abort) state_nxt = ST_ABORT;
    end

    always_ff @(posedge clk) begin
        if (reset_begin) begin
            state        <= ST_IDLE;
            frame_num    <= 2'd0;
            exp_frag     <= 2'd0;
            cnt          <= '0;
            hb           <= '0;
            hb_n         <= 3'd0;
            pRX_DV       <= 1'b0;
            pRX_VALID    <= 1'b0;
            pRX_DATA     <= 8'h00;
            pRX_ER       <= 1'b0;
            frame_active <= 1'b0;
        end else begin
            state     <= state_nxt;
            pRX_VALID <= 1'b0;
            pRX_ER    <= 1'b0;
            if (start) begin
                frame_num    <= sd.idx;
                exp_frag     <= 2'd0;
                cnt          <= '0;
                hb_n         <= 3'd0;
                frame_active <= 1'b1;
                pRX_DV       <= 1'b1;
                pRX_VALID    <= 1'b1;
                pRX_DATA     <= SFD_B;
            end
            if (fcnt_ok) cnt <= '0;
            if (push) begin
                hb <= {rRX_DATA, hb[3:1]};
                if (cnt != '1) cnt <= cnt + CNT_W'(1);
                if (hb_full) begin
                    pRX_VALID <= 1'b1;
                    pRX_DATA  <= hb[0];
                end else begin
                    hb_n <= hb_n + 3'd1;
                end
            end
            if (flush_pop) begin
                hb        <= {8'h00, hb[3:1]};
                hb_n      <= hb_n - 3'd1;
                pRX_VALID <= 1'b1;
                pRX_DATA  <= hb[0];
            end
            if (frag_end) begin
                hb_n     <= 3'd0;
                exp_frag <= exp_frag + 2'd1;
            end
            if (close) begin
                pRX_DV       <= 1'b0;
                frame_active <= 1'b0;
            end
            if (abort) begin
                pRX_ER <= 1'b1;
                pRX_DV <= 1'b1;
            end
            if (clr) begin
                pRX_DV       <= 1'b0;
                frame_active <= 1'b0;
                hb_n         <= 3'd0;
                exp_frag     <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_mmsr_preempt_rx_proc.sv
// Scoreboard bench: stimulus queues expected pRX events,
// a negedge monitor pops and compares them.
module tb_mmsr_preempt_rx_proc;

    logic       clk = 1'b0;
    logic       reset_begin;
    logic       rRxDv;
    logic       rByteReady;
    logic [7:0] rRX_DATA;
    logic       pRX_DV;
    logic       pRX_VALID;
    logic [7:0] pRX_DATA;
    logic       pRX_ER;
    logic       frame_active;

    localparam logic [1:0] K_BYTE = 2'd0;
    localparam logic [1:0] K_ER   = 2'd1;
    localparam logic [1:0] K_END  = 2'd2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_evt = 0;
    logic dv_q = 1'b0;
    logic er_q = 1'b0;

    logic [9:0]  exp_q[$];
    logic [7:0]  tx_q[$];
    logic [31:0] run_crc;

    mmsr_preempt_rx_proc #(
        .MIN_FRAG_BYTES (13),
        .CNT_W          (11)
    ) dut (
        .clk          (clk),
        .reset_begin  (reset_begin),
        .rRxDv        (rRxDv),
        .rByteReady   (rByteReady),
        .rRX_DATA     (rRX_DATA),
        .pRX_DV       (pRX_DV),
        .pRX_VALID    (pRX_VALID),
        .pRX_DATA     (pRX_DATA),
        .pRX_ER       (pRX_ER),
        .frame_active (frame_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h",
                     name, act, exp);
        end
    endtask

    task automatic expect_evt(input logic [1:0] k,
                              input logic [7:0] d);
        logic [9:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got kind %0d data 0x%0h, expected none",
                     k, d);
        end else begin
            e = exp_q.pop_front();
            check("out_evt", {22'h0, k, d}, {22'h0, e});
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (reset_begin) begin
                dv_q = 1'b0;
                er_q = 1'b0;
            end else begin
                if (pRX_VALID) begin
                    check("valid_dv", 32'(pRX_DV), 32'd1);
                    expect_evt(K_BYTE, pRX_DATA);
                    last_evt = cyc;
                end
                if (pRX_ER) begin
                    check("er_shape", 32'({pRX_VALID, pRX_DV}), 32'd1);
                    expect_evt(K_ER, 8'h00);
                    last_evt = cyc;
                end
                if (er_q) begin
                    check("abort_dv_drop", 32'(pRX_DV), 32'd0);
                end else if (dv_q && !pRX_DV) begin
                    expect_evt(K_END, 8'h00);
                    check("end_gap", 32'(cyc - last_evt), 32'd1);
                end
                dv_q = pRX_DV;
                er_q = pRX_ER;
            end
        end
    end

    function automatic logic [31:0] crc_upd(input logic [31:0] c,
                                            input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_tx(input logic [7:0] b, input bit out);
        tx_q.push_back(b);
        if (out) exp_q.push_back({K_BYTE, b});
    endtask

    task automatic add_pre(input int n);
        for (int i = 0; i < n; i++) add_tx(8'h55, 1'b0);
    endtask

    task automatic add_data(input string s, input bit out);
        logic [7:0] b;
        for (int i = 0; i < s.len(); i++) begin
            b = s[i];
            add_tx(b, out);
            run_crc = crc_upd(run_crc, b);
        end
    endtask

    task automatic add_fcs(input bit mcrc, input bit out);
        logic [31:0] f;
        logic [7:0]  b;
        f = ~run_crc;
        for (int i = 0; i < 4; i++) begin
            b = f[8*i +: 8];
            if (mcrc && i >= 2) b = ~b;
            add_tx(b, out);
        end
    endtask

    task automatic send_bytes();
        while (tx_q.size() > 0) begin
            rByteReady = 1'b1;
            rRX_DATA   = tx_q.pop_front();
            tick();
            rByteReady = 1'b0;
            tick();
        end
    endtask

    task automatic burst();
        rRxDv = 1'b1;
        tick();
        tick();
        send_bytes();
        rRxDv = 1'b0;
        repeat (16) tick();
    endtask

    task automatic check_levels(input string name,
                                input logic dv,
                                input logic fa);
        @(negedge clk);
        check({name, "_dv"}, 32'(pRX_DV), 32'(dv));
        check({name, "_fa"}, 32'(frame_active), 32'(fa));
    endtask

    initial begin
        reset_begin = 1'b1;
        rRxDv       = 1'b0;
        rByteReady  = 1'b0;
        rRX_DATA    = 8'h00;
        repeat (3) tick();
        @(negedge clk);
        check("rst_dv", 32'(pRX_DV), 32'd0);
        check("rst_valid", 32'(pRX_VALID), 32'd0);
        check("rst_er", 32'(pRX_ER), 32'd0);
        check("rst_data", 32'(pRX_DATA), 32'd0);
        check("rst_fa", 32'(frame_active), 32'd0);
        tick();
        reset_begin = 1'b0;
        tick();

        // 1: single final frame, check value CBF43926
        add_pre(6);
        add_tx(8'hE6, 1'b0);
        exp_q.push_back({K_BYTE, 8'hD5});
        run_crc = 32'hFFFFFFFF;
        add_data("123456789", 1'b1);
        add_tx(8'h26, 1'b1);
        add_tx(8'h39, 1'b1);
        add_tx(8'hF4, 1'b1);
        add_tx(8'hCB, 1'b1);
        exp_q.push_back({K_END, 8'h00});
        burst();
        check_levels("t1_end", 1'b0, 1'b0);
        check("t1_drained", 32'(exp_q.size()), 32'd0);

        // 2: first fragment closed by mCRC
        add_pre(6);
        add_tx(8'hE6, 1'b0);
        exp_q.push_back({K_BYTE, 8'hD5});
        run_crc = 32'hFFFFFFFF;
        add_data("123456789", 1'b1);
        add_tx(8'h26, 1'b0);
        add_tx(8'h39, 1'b0);
        add_tx(8'h0B, 1'b0);
        add_tx(8'h34, 1'b0);
        burst();
        check_levels("t2_frag1", 1'b1, 1'b1);
        check("t2_frag1_drained", 32'(exp_q.size()), 32'd0);

        // 3: express frame interleaved, no pRX output
        add_pre(6);
        add_tx(8'hD5, 1'b0);
        for (int i = 0; i < 64; i++) add_tx(8'(i), 1'b0);
        burst();
        check_levels("t3_express", 1'b1, 1'b1);

        add_pre(5);
        add_tx(8'h61, 1'b0);
        add_tx(8'hE6, 1'b0);
        add_data("abcdefgh", 1'b1);
        add_fcs(1'b0, 1'b1);
        exp_q.push_back({K_END, 8'h00});
        burst();
        check_levels("t2_end", 1'b0, 1'b0);
        check("t2_drained", 32'(exp_q.size()), 32'd0);

        // 4: wrong frag_cnt on the continuation
        add_pre(6);
        add_tx(8'hE6, 1'b0);
        exp_q.push_back({K_BYTE, 8'hD5});
        run_crc = 32'hFFFFFFFF;
        add_data("123456789", 1'b1);
        add_tx(8'h26, 1'b0);
        add_tx(8'h39, 1'b0);
        add_tx(8'h0B, 1'b0);
        add_tx(8'h34, 1'b0);
        burst();
        check_levels("t4_frag1", 1'b1, 1'b1);
        add_pre(5);
        add_tx(8'h61, 1'b0);
        add_tx(8'h4C, 1'b0);
        add_data("qrstuvwx", 1'b0);
        exp_q.push_back({K_ER, 8'h00});
        burst();
        check_levels("t4_end", 1'b0, 1'b0);
        check("t4_drained", 32'(exp_q.size()), 32'd0);

        // 5: mCRC-closed fragment one byte too short
        add_pre(6);
        add_tx(8'hE6, 1'b0);
        exp_q.push_back({K_BYTE, 8'hD5});
        run_crc = 32'hFFFFFFFF;
        add_data("12345678", 1'b1);
        add_fcs(1'b1, 1'b0);
        exp_q.push_back({K_ER, 8'h00});
        burst();
        check_levels("t5_end", 1'b0, 1'b0);
        check("t5_drained", 32'(exp_q.size()), 32'd0);

        // 6: reset in the middle of DATA
        add_pre(6);
        add_tx(8'hE6, 1'b0);
        exp_q.push_back({K_BYTE, 8'hD5});
        add_data("ABCDEF", 1'b0);
        exp_q.push_back({K_BYTE, 8'h41});
        exp_q.push_back({K_BYTE, 8'h42});
        rRxDv = 1'b1;
        tick();
        tick();
        send_bytes();
        repeat (3) tick();
        check("t6_pre_dv", 32'(pRX_DV), 32'd1);
        reset_begin = 1'b1;
        tick();
        @(negedge clk);
        check("t6_rst_dv", 32'(pRX_DV), 32'd0);
        check("t6_rst_valid", 32'(pRX_VALID), 32'd0);
        check("t6_rst_er", 32'(pRX_ER), 32'd0);
        check("t6_rst_fa", 32'(frame_active), 32'd0);
        rRxDv = 1'b0;
        tick();
        reset_begin = 1'b0;
        tick();
        add_pre(5);
        add_tx(8'h61, 1'b0);
        add_tx(8'hE6, 1'b0);
        add_data("123", 1'b0);
        burst();
        check_levels("t6_end", 1'b0, 1'b0);
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "timeout");
    end

endmodule
